// File: rtl/minirisc_sort_wrapper.sv
// minirisc_sort_wrapper
//   KGP miniRISC multi-cycle core with its program ROM and data RAM.
//   After reset the built-in program bubble-sorts dmem[0..N_ELEM-1]
//   (ascending, signed) and then halts.
// Ports:
//   clk    - single clock, rising edge
//   rst    - asynchronous active-high reset (core only; data RAM keeps contents)
//   select - 1: out = dmem[inp][15:0], 0: out = PC[15:0]
//   inp    - debug read address into data RAM
//   out    - combinational debug output
// TEST_PROG=1 swaps in a short SLT/ST unit-check program.
module minirisc_sort_wrapper #(
  parameter int DMEM_DEPTH = 1024,
  parameter int IMEM_DEPTH = 64,
  parameter int N_ELEM     = 10,
  parameter bit TEST_PROG  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        select,
  input  logic [9:0]  inp,
  output logic [15:0] out
);
  localparam int IAW = $clog2(IMEM_DEPTH);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_LD   = 6'd2;
  localparam logic [5:0] OP_ST   = 6'd3;
  localparam logic [5:0] OP_BR   = 6'd4;
  localparam logic [5:0] OP_BZ   = 6'd5;
  localparam logic [5:0] OP_BNZ  = 6'd6;
  localparam logic [5:0] OP_BLTZ = 6'd7;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [15:0] F_ADD = 16'd0;
  localparam logic [15:0] F_AND = 16'd2;
  localparam logic [15:0] F_SLT = 16'd5;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Program ROM. Unused words hold HALT so a stray PC stops the core.
  // Sort register use: r1 passes left, r2 index j, r3 inner count,
  // r4/r5 = dmem[j]/dmem[j+1], r6 = swap flag.
  function automatic logic [31:0] rom(input logic [IAW-1:0] a);
    logic [31:0] w;
    w = enc(OP_HALT, 5'd0, 5'd0, 16'd0);
    if (TEST_PROG) begin
      case (int'(a))
        0: w = enc(OP_ADDI, 5'd1, 5'd0, 16'd5);
        1: w = enc(OP_ADDI, 5'd2, 5'd0, 16'hfff9);   // -7
        2: w = enc(OP_R,    5'd1, 5'd2, F_SLT);
        3: w = enc(OP_ST,   5'd0, 5'd1, 16'd20);
        default: ;
      endcase
    end else begin
      case (int'(a))
        0:  w = enc(OP_ADDI, 5'd1, 5'd0, 16'(N_ELEM - 1));
        1:  w = enc(OP_R,    5'd2, 5'd0, F_AND);       // outer: j = 0
        2:  w = enc(OP_R,    5'd3, 5'd0, F_AND);
        3:  w = enc(OP_R,    5'd3, 5'd1, F_ADD);       // r3 = r1
        4:  w = enc(OP_LD,   5'd2, 5'd4, 16'd0);       // inner
        5:  w = enc(OP_LD,   5'd2, 5'd5, 16'd1);
        6:  w = enc(OP_R,    5'd6, 5'd0, F_AND);
        7:  w = enc(OP_R,    5'd6, 5'd5, F_ADD);
        8:  w = enc(OP_R,    5'd6, 5'd4, F_SLT);       // r6 = dmem[j+1] < dmem[j]
        9:  w = enc(OP_BZ,   5'd6, 5'd0, 16'd2);       // in order -> 12
        10: w = enc(OP_ST,   5'd2, 5'd5, 16'd0);
        11: w = enc(OP_ST,   5'd2, 5'd4, 16'd1);
        12: w = enc(OP_ADDI, 5'd2, 5'd0, 16'd1);
        13: w = enc(OP_ADDI, 5'd3, 5'd0, 16'hffff);
        14: w = enc(OP_BNZ,  5'd3, 5'd0, 16'hfff5);    // -> 4
        15: w = enc(OP_ADDI, 5'd1, 5'd0, 16'hffff);
        16: w = enc(OP_BNZ,  5'd1, 5'd0, 16'hfff0);    // -> 1
        default: ;                                     // 17: HALT
      endcase
    end
    return w;
  endfunction

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;
  state_t state, state_nxt;

  logic [31:0] pc, ir, opa, opb, res, alu, simm;
  logic [31:0] gpr [32];
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        take, is_mem;
  logic        ir_ld, opr_ld, res_ld, ld_en, st_en, wb_en;

  // Power-up image only; reset deliberately leaves the RAM alone.
  logic [31:0] dmem [DMEM_DEPTH] = '{0: 32'd9, 1: 32'd3, 2: 32'd7, 3: 32'd1, 4: 32'd8,
                                     5: 32'd2, 6: 32'd6, 7: 32'd0, 8: 32'd5, 9: 32'd4,
                                     default: 32'd0};

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign simm   = {{16{ir[15]}}, ir[15:0]};
  assign is_mem = (op == OP_LD) || (op == OP_ST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = (op == OP_HALT) ? HALTED : EXEC;
      EXEC:    state_nxt = is_mem ? MEM : WB;
      MEM:     state_nxt = WB;
      WB:      state_nxt = FETCH;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    ir_ld  = 1'b0;
    opr_ld = 1'b0;
    res_ld = 1'b0;
    ld_en  = 1'b0;
    st_en  = 1'b0;
    wb_en  = 1'b0;
    case (state)
      FETCH:  ir_ld  = 1'b1;
      DECODE: opr_ld = 1'b1;
      EXEC:   res_ld = 1'b1;
      MEM: begin
        ld_en = (op == OP_LD);
        st_en = (op == OP_ST);
      end
      WB:     wb_en  = 1'b1;
      default: ;
    endcase
  end

  // ALU and branch condition. opa/ir are stable from DECODE through WB,
  // so take can be used directly at WB without latching it.
  always_comb begin
    alu  = opa;
    take = 1'b0;
    case (op)
      OP_R: begin
        case (ir[3:0])
          4'd0: alu = opa + opb;
          4'd1: alu = opa - opb;
          4'd2: alu = opa & opb;
          4'd3: alu = opa | opb;
          4'd4: alu = opa ^ opb;
          4'd5: alu = {31'd0, $signed(opa) < $signed(opb)};
          default: alu = opa;                          // undefined func: rs unchanged
        endcase
      end
      OP_ADDI, OP_LD, OP_ST: alu = opa + simm;
      OP_BR:   take = 1'b1;
      OP_BZ:   take = (opa == 32'd0);
      OP_BNZ:  take = (opa != 32'd0);
      OP_BLTZ: take = opa[31];
      default: ;
    endcase
  end

  // Core datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= 32'd0;
      ir  <= 32'd0;
      opa <= 32'd0;
      opb <= 32'd0;
      res <= 32'd0;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else begin
      if (ir_ld)  ir <= rom(pc[IAW-1:0]);
      if (opr_ld) begin
        opa <= gpr[rs];
        opb <= gpr[rt];
      end
      if (res_ld) res <= alu;
      if (ld_en)  res <= dmem[res[9:0]];
      if (wb_en) begin
        pc <= take ? pc + 32'd1 + simm : pc + 32'd1;
        if ((op == OP_R || op == OP_ADDI) && rs != 5'd0) gpr[rs] <= res;
        else if (op == OP_LD && rt != 5'd0)              gpr[rt] <= res;
      end
    end
  end

  // Data RAM write port; debug read below sees the old word until the edge.
  always_ff @(posedge clk) begin
    if (st_en) dmem[res[9:0]] <= opb;
  end

  assign out = select ? dmem[inp][15:0] : pc[15:0];

endmodule

// File: tb/tb_minirisc_sort_wrapper.sv
module tb_minirisc_sort_wrapper;
  localparam int HALT_PC   = 17;   // address of HALT in the sort program
  localparam int T_HALT_PC = 4;    // address of HALT in the unit-check program

  logic        clk = 1'b0;
  logic        rst = 1'b0, rst_t = 1'b0;
  logic        select = 1'b0, select_t = 1'b0;
  logic [9:0]  inp = 10'd0, inp_t = 10'd0;
  logic [15:0] out, out_t;

  int n_vec = 0;
  int n_err = 0;
  int model [10] = '{9, 3, 7, 1, 8, 2, 6, 0, 5, 4};

  always #5 clk = ~clk;

  minirisc_sort_wrapper dut (
    .clk(clk), .rst(rst), .select(select), .inp(inp), .out(out)
  );

  minirisc_sort_wrapper #(.TEST_PROG(1'b1)) dut_t (
    .clk(clk), .rst(rst_t), .select(select_t), .inp(inp_t), .out(out_t)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: ascending signed sort of the current model contents.
  function automatic void sort_model();
    for (int i = 1; i < 10; i++) begin
      int v = model[i];
      int j = i - 1;
      while (j >= 0 && model[j] > v) begin
        model[j+1] = model[j];
        j--;
      end
      model[j+1] = v;
    end
  endfunction

  // Random debug traffic while the core runs; reads must never disturb it.
  task automatic run_clocks(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      select = 1'($urandom_range(0, 1));
      inp    = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 15))
                                           : 10'($urandom_range(0, 1023));
      #2;
      if (select) begin
        if (inp < 10'd10) chk("run_word_in_set", {31'd0, out < 16'd10}, 32'd1);
        else              chk("run_untouched", {16'd0, out}, 32'd0);
      end else begin
        chk("run_pc_range", {31'd0, out <= 16'(HALT_PC)}, 32'd1);
      end
    end
  endtask

  task automatic pulse_rst_check(input string tag);
    @(posedge clk); #3;
    select = 1'b0;
    rst = 1'b1;
    #1 chk(tag, {16'd0, out}, 32'd0);
    #1 rst = 1'b0;
  endtask

  task automatic check_sorted(input string tag);
    @(negedge clk);
    select = 1'b1;
    for (int i = 0; i < 10; i++) begin
      inp = 10'(i);
      #1 chk(tag, {16'd0, out}, 32'(model[i]));
    end
  endtask

  task automatic check_halt_hold();
    @(negedge clk);
    select = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("halt_pc_hold", {16'd0, out}, 32'(HALT_PC));
    end
  endtask

  initial begin
    int a, b;
    // 1 ns reset pulse before the first edge
    #2 rst = 1'b1; rst_t = 1'b1;
    #1 rst = 1'b0; rst_t = 1'b0;
    #1 chk("reset_pc", {16'd0, out}, 32'd0);
    chk("reset_pc_t", {16'd0, out_t}, 32'd0);

    // Reset at clock 500, while pass 2 is comparing (no store pending)
    run_clocks(500);
    pulse_rst_check("midrun_reset_pc");
    run_clocks(20000);
    sort_model();
    check_sorted("sorted_after_midrun_reset");
    check_halt_hold();

    @(negedge clk);
    select = 1'b1;
    inp = 10'd10;   #1 chk("untouched_10", {16'd0, out}, 32'd0);
    inp = 10'd1023; #1 chk("untouched_1023", {16'd0, out}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      inp = 10'($urandom_range(10, 1023));
      #1 chk("untouched_rand", {16'd0, out}, 32'd0);
    end

    // Re-run over already sorted data, interrupted at a random point
    pulse_rst_check("rerun_reset_pc");
    run_clocks(int'($urandom_range(50, 1500)));
    pulse_rst_check("rerun_midreset_pc");
    run_clocks(20000);
    sort_model();
    check_sorted("sorted_after_rerun");
    check_halt_hold();

    // Unit-check program: SLT of 5 and -7 stored to dmem[20]
    a = 5; b = -7;
    @(negedge clk);
    select_t = 1'b1; inp_t = 10'd20;
    #1 chk("t_slt_store", {16'd0, out_t}, 32'((a < b) ? 1 : 0));
    select_t = 1'b0;
    #1 chk("t_halt_pc", {16'd0, out_t}, 32'(T_HALT_PC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
